// File: rtl/ts_injection_schedule_pkg.sv
// rtl/ts_injection_schedule_pkg.sv - shared types and sizes for the TS injection scheduler
package ts_injection_schedule_pkg;

  localparam int FLOW_ADDR_W = 5;
  localparam int LIST_DEPTH  = 32;
  localparam int LIST_ADDR_W = 5;
  localparam int LIST_DATA_W = 6;
  localparam int SLOT_CYC_W  = 16;
  localparam int SLOT_NUM_W  = 6;

  typedef enum logic [1:0] {
    IDLE_S  = 2'd0,
    READ_S  = 2'd1,
    ISSUE_S = 2'd2
  } tis_state_e;

  // Wraps on >= so a slot count shrunk below the current index recovers at once.
  function automatic logic [LIST_ADDR_W-1:0] next_slot_index(
    input logic [LIST_ADDR_W-1:0] idx,
    input logic [SLOT_NUM_W-1:0]  num
  );
    if ({1'b0, idx} >= (num - 6'd1)) begin
      return '0;
    end
    return idx + 5'd1;
  endfunction

endpackage

// File: rtl/injection_list_table.sv
// rtl/injection_list_table.sv - 32x6 injection list, synchronous write, registered read
module injection_list_table
  import ts_injection_schedule_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_wr,
  input  logic [LIST_ADDR_W-1:0] iv_waddr,
  input  logic [LIST_DATA_W-1:0] iv_wdata,
  input  logic                   i_rd,
  input  logic [LIST_ADDR_W-1:0] iv_raddr,
  output logic [LIST_DATA_W-1:0] ov_rdata
);

  logic [LIST_DATA_W-1:0] r_mem [LIST_DEPTH];
  logic [LIST_DATA_W-1:0] r_rdata;

  // Write and read sample the array on the same edge, so a same-address read sees old data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < LIST_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_rdata <= '0;
    end else begin
      if (i_wr) begin
        r_mem[iv_waddr] <= iv_wdata;
      end
      if (i_rd) begin
        r_rdata <= r_mem[iv_raddr];
      end
    end
  end

  assign ov_rdata = r_rdata;

endmodule

// File: rtl/ts_injection_schedule.sv
// rtl/ts_injection_schedule.sv - slot timer and injection request handshake for TS flows
module ts_injection_schedule
  import ts_injection_schedule_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_enable,
  input  logic [SLOT_CYC_W-1:0]  iv_slot_cycles,
  input  logic [SLOT_NUM_W-1:0]  iv_slot_num,
  input  logic                   i_list_wr,
  input  logic [LIST_ADDR_W-1:0] iv_list_waddr,
  input  logic [LIST_DATA_W-1:0] iv_list_wdata,
  output logic [FLOW_ADDR_W-1:0] ov_ts_injection_addr,
  output logic                   o_ts_injection_addr_wr,
  input  logic                   i_ts_injection_addr_ack,
  output logic [LIST_ADDR_W-1:0] ov_slot_index,
  output logic                   o_overrun_pulse,
  output logic [1:0]             ov_tis_state
);

  logic [SLOT_CYC_W-1:0]  r_cycle_cnt;
  logic [LIST_ADDR_W-1:0] r_slot_index;
  tis_state_e             r_state;
  logic [FLOW_ADDR_W-1:0] r_addr;
  logic                   r_wr;
  logic                   r_overrun;

  logic                   w_cfg_ok;
  logic                   w_last_cycle;
  logic                   w_slot_pulse;
  logic                   w_rd_en;
  logic [LIST_DATA_W-1:0] w_list_rdata;

  assign w_cfg_ok     = (iv_slot_cycles != '0) && (iv_slot_num != '0);
  assign w_last_cycle = (r_cycle_cnt >= (iv_slot_cycles - 16'd1));
  assign w_slot_pulse = i_enable && w_cfg_ok && w_last_cycle;
  assign w_rd_en      = w_slot_pulse && (r_state == IDLE_S);

  injection_list_table u_list (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_wr     (i_list_wr),
    .iv_waddr (iv_list_waddr),
    .iv_wdata (iv_list_wdata),
    .i_rd     (w_rd_en),
    .iv_raddr (r_slot_index),
    .ov_rdata (w_list_rdata)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cycle_cnt  <= '0;
      r_slot_index <= '0;
    end else if (!i_enable || !w_cfg_ok) begin
      r_cycle_cnt  <= '0;
      if (!i_enable) begin
        r_slot_index <= '0;
      end
    end else if (w_last_cycle) begin
      r_cycle_cnt  <= '0;
      r_slot_index <= next_slot_index(r_slot_index, iv_slot_num);
    end else begin
      r_cycle_cnt  <= r_cycle_cnt + 16'd1;
    end
  end

  // Handshake runs independently of i_enable so a pending request is never abandoned.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE_S;
      r_addr    <= '0;
      r_wr      <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_slot_pulse && (r_state != IDLE_S);
      case (r_state)
        IDLE_S: begin
          if (w_slot_pulse) begin
            r_state <= READ_S;
          end
        end
        READ_S: begin
          if (w_list_rdata[LIST_DATA_W-1]) begin
            r_addr  <= w_list_rdata[FLOW_ADDR_W-1:0];
            r_wr    <= 1'b1;
            r_state <= ISSUE_S;
          end else begin
            r_state <= IDLE_S;
          end
        end
        ISSUE_S: begin
          if (i_ts_injection_addr_ack) begin
            r_addr  <= '0;
            r_wr    <= 1'b0;
            r_state <= IDLE_S;
          end
        end
        default: begin
          r_addr  <= '0;
          r_wr    <= 1'b0;
          r_state <= IDLE_S;
        end
      endcase
    end
  end

  assign ov_ts_injection_addr   = r_addr;
  assign o_ts_injection_addr_wr = r_wr;
  assign ov_slot_index          = r_slot_index;
  assign o_overrun_pulse        = r_overrun;
  assign ov_tis_state           = r_state;

endmodule

// File: tb/tb_ts_injection_schedule.sv
// tb/tb_ts_injection_schedule.sv - directed self-checking bench for ts_injection_schedule
module tb_ts_injection_schedule;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [15:0] slot_cycles;
  logic [5:0]  slot_num;
  logic        list_wr;
  logic [4:0]  list_waddr;
  logic [5:0]  list_wdata;
  logic [4:0]  inj_addr;
  logic        inj_wr;
  logic        ack;
  logic [4:0]  slot_index;
  logic        overrun;
  logic [1:0]  tis_state;

  int checks = 0;
  int errors = 0;

  ts_injection_schedule dut (
    .i_clk                   (clk),
    .i_rst_n                 (rst_n),
    .i_enable                (enable),
    .iv_slot_cycles          (slot_cycles),
    .iv_slot_num             (slot_num),
    .i_list_wr               (list_wr),
    .iv_list_waddr           (list_waddr),
    .iv_list_wdata           (list_wdata),
    .ov_ts_injection_addr    (inj_addr),
    .o_ts_injection_addr_wr  (inj_wr),
    .i_ts_injection_addr_ack (ack),
    .ov_slot_index           (slot_index),
    .o_overrun_pulse         (overrun),
    .ov_tis_state            (tis_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic list_write(input logic [4:0] a, input logic [5:0] d);
    list_wr    = 1'b1;
    list_waddr = a;
    list_wdata = d;
    cyc(1);
    list_wr    = 1'b0;
  endtask

  task automatic drain();
    enable = 1'b0;
    ack    = 1'b1;
    cyc(3);
    ack    = 1'b0;
    cyc(1);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; slot_cycles = '0; slot_num = '0;
    list_wr = 1'b0; list_waddr = '0; list_wdata = '0; ack = 1'b0;
    cyc(3);
    chk("rst_wr", inj_wr, 0);
    chk("rst_addr", inj_addr, 0);
    chk("rst_index", slot_index, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_state", tis_state, 0);
    rst_n = 1'b1;
    cyc(1);

    list_write(5'd0, 6'b100111);
    list_write(5'd1, 6'b000000);

    // Basic request: slot 0 valid -> addr 7, then ack.
    slot_cycles = 16'd4; slot_num = 6'd2; enable = 1'b1;
    cyc(3);
    chk("s1_wr_k3", inj_wr, 0);
    chk("s1_state_k3", tis_state, 0);
    cyc(1);
    chk("s1_state_k4", tis_state, 1);
    chk("s1_index_k4", slot_index, 1);
    cyc(1);
    chk("s1_wr_k5", inj_wr, 1);
    chk("s1_addr_k5", inj_addr, 7);
    chk("s1_state_k5", tis_state, 2);
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
    chk("s1_wr_k6", inj_wr, 0);
    chk("s1_addr_k6", inj_addr, 0);
    chk("s1_state_k6", tis_state, 0);

    // Slot 1 is invalid; index wraps 1 -> 0.
    cyc(2);
    chk("s2_state_k8", tis_state, 1);
    chk("s2_index_k8", slot_index, 0);
    cyc(1);
    chk("s2_state_k9", tis_state, 0);
    chk("s2_wr_k9", inj_wr, 0);
    chk("s2_overrun_k9", overrun, 0);

    // Ack withheld: skipped slots raise overrun, address held; then double ack.
    enable = 1'b0;
    cyc(1);
    slot_cycles = 16'd2; enable = 1'b1;
    cyc(2);
    chk("s3_state_k2", tis_state, 1);
    cyc(1);
    chk("s3_wr_k3", inj_wr, 1);
    chk("s3_addr_k3", inj_addr, 7);
    chk("s3_ovr_k3", overrun, 0);
    cyc(1);
    chk("s3_ovr_k4", overrun, 1);
    chk("s3_addr_k4", inj_addr, 7);
    cyc(1);
    chk("s3_ovr_k5", overrun, 0);
    chk("s3_addr_k5", inj_addr, 7);
    cyc(1);
    chk("s3_ovr_k6", overrun, 1);
    chk("s3_wr_k6", inj_wr, 1);
    cyc(1);
    chk("s3_ovr_k7", overrun, 0);
    chk("s3_addr_k7", inj_addr, 7);
    ack = 1'b1;
    cyc(1);
    chk("s3_wr_k8", inj_wr, 0);
    chk("s3_state_k8", tis_state, 0);
    chk("s3_ovr_k8", overrun, 1);
    chk("s3_index_k8", slot_index, 0);
    cyc(1);
    chk("s3_state_k9", tis_state, 0);
    chk("s3_wr_k9", inj_wr, 0);
    chk("s3_ovr_k9", overrun, 0);
    ack = 1'b0;
    cyc(1);
    chk("s3_state_k10", tis_state, 1);
    drain();
    chk("drain1_state", tis_state, 0);
    chk("drain1_wr", inj_wr, 0);

    // Zero slot_cycles or zero slot_num: no pulses.
    slot_cycles = 16'd0; slot_num = 6'd2; enable = 1'b1;
    cyc(5);
    chk("zc_index", slot_index, 0);
    chk("zc_state", tis_state, 0);
    slot_cycles = 16'd2; slot_num = 6'd0;
    cyc(5);
    chk("zn_index", slot_index, 0);
    chk("zn_state", tis_state, 0);
    enable = 1'b0;
    cyc(1);

    // slot_cycles=1 pulses every cycle; shrink slot_num 8 -> 3 at index 5.
    slot_cycles = 16'd1; slot_num = 6'd8; enable = 1'b1;
    cyc(1);
    chk("s4_index_k1", slot_index, 1);
    cyc(1);
    chk("s4_index_k2", slot_index, 2);
    cyc(3);
    chk("s4_index_k5", slot_index, 5);
    slot_num = 6'd3;
    cyc(1);
    chk("s4_index_k6", slot_index, 0);
    cyc(1);
    chk("s4_index_k7", slot_index, 1);
    drain();
    chk("drain2_state", tis_state, 0);
    chk("drain2_index", slot_index, 0);

    // Reset during ISSUE_S drops wr asynchronously.
    slot_cycles = 16'd1; slot_num = 6'd1; enable = 1'b1;
    cyc(2);
    chk("s5_wr_k2", inj_wr, 1);
    chk("s5_state_k2", tis_state, 2);
    #1 rst_n = 1'b0;
    #1;
    chk("s5_async_wr", inj_wr, 0);
    chk("s5_async_addr", inj_addr, 0);
    chk("s5_async_state", tis_state, 0);
    enable = 1'b0;
    cyc(1);
    rst_n = 1'b1;

    // After release list[0] is invalid; a same-edge write is not seen by that read.
    enable = 1'b1;
    list_wr = 1'b1; list_waddr = 5'd0; list_wdata = 6'b101001;
    cyc(1);
    list_wr = 1'b0;
    chk("s6_state_k1", tis_state, 1);
    cyc(1);
    chk("s6_state_k2", tis_state, 0);
    chk("s6_wr_k2", inj_wr, 0);
    chk("s6_ovr_k2", overrun, 1);
    cyc(1);
    chk("s6_state_k3", tis_state, 1);
    cyc(1);
    chk("s6_wr_k4", inj_wr, 1);
    chk("s6_addr_k4", inj_addr, 9);
    drain();
    chk("final_wr", inj_wr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ts_injection_schedule.md
TS_INJECTION_SCHEDULE -- requirements
Module: ts_injection_schedule

Interface
REQ-001 SHALL have i_clk input 1: single clock; all logic on its rising edge.
REQ-002 SHALL have i_rst_n input 1: asynchronous, active-low reset.
REQ-003 SHALL have i_enable input 1: 1 = slot timing runs; 0 = slot timing held at zero.
REQ-004 SHALL have iv_slot_cycles input 16: clock cycles per injection slot.
REQ-005 SHALL have iv_slot_num input 6: slots per schedule cycle, legal 1..32.
REQ-006 SHALL have i_list_wr input 1, iv_list_waddr input 5, iv_list_wdata input 6 ({valid, flow_addr[4:0]}): injection list write port.
REQ-007 SHALL have ov_ts_injection_addr output 5: TS flow address requested for injection.
REQ-008 SHALL have o_ts_injection_addr_wr output 1: request valid, held until acknowledged.
REQ-009 SHALL have i_ts_injection_addr_ack input 1: acknowledge from the injection manager.
REQ-010 SHALL have ov_slot_index output 5: current slot index.
REQ-011 SHALL have o_overrun_pulse output 1: one-cycle pulse when a slot is skipped.
REQ-012 SHALL have ov_tis_state output 2: current FSM state, for debug.

Function
REQ-013 Cycle counter SHALL count 0..iv_slot_cycles-1 while i_enable=1; slot pulse SHALL occur in the cycle counter equals iv_slot_cycles-1, then wrap to 0.
REQ-014 iv_slot_cycles=0 or iv_slot_num=0 SHALL produce no slot pulses; iv_slot_cycles=1 SHALL pulse every cycle.
REQ-015 On each slot pulse ov_slot_index SHALL increment; it SHALL wrap to 0 when ov_slot_index >= iv_slot_num-1, which covers a config shrink mid-run.
REQ-016 i_enable=0 SHALL clear the cycle counter and ov_slot_index next cycle, and SHALL NOT abort a handshake already in progress.
REQ-017 FSM states SHALL be IDLE_S=0, READ_S=1, ISSUE_S=2.
REQ-018 IDLE_S: on slot pulse, read list entry at the pre-increment slot index, then go to READ_S.
REQ-019 READ_S: list read data SHALL be valid this cycle (1-cycle registered read).
REQ-020 READ_S, entry valid=1: ov_ts_injection_addr<=flow_addr, o_ts_injection_addr_wr<=1, go to ISSUE_S.
REQ-021 READ_S, entry valid=0: go to IDLE_S with no request issued.
REQ-022 ISSUE_S: ov_ts_injection_addr and wr SHALL stay stable until ack=1 is sampled.
REQ-023 ISSUE_S, ack=1 sampled: next cycle wr<=0, addr<=0, go to IDLE_S.
REQ-024 i_ts_injection_addr_ack SHALL be ignored outside ISSUE_S, so a stray second ack has no effect.
REQ-025 Latency: slot pulse at cycle N gives wr=1 at cycle N+2.
REQ-026 A slot pulse while the FSM is not in IDLE_S SHALL skip that slot: index still advances and o_overrun_pulse=1 the next cycle.
REQ-027 List write: synchronous, 32 entries.
REQ-028 Simultaneous write and read of the same address SHALL return the old contents.

Reset
REQ-029 Reset SHALL set all outputs to 0, the FSM to IDLE_S, both counters to 0, and all list entries to 0 (invalid).
REQ-030 Reset asserted mid-handshake SHALL drop wr immediately (asynchronously); no request SHALL resume after release.

Structure
REQ-031 Shared package SHALL hold the state encodings, FLOW_ADDR_W=5, LIST_DEPTH=32 and LIST_DATA_W=6.
REQ-032 The list SHALL be sub-module injection_list_table: 32x6 register file, synchronous write, registered read, async active-low clear.

Verification
REQ-033 List[0]={1,5'd7}, slot_cycles=4, slot_num=2, enable: first pulse -> wr=1 with addr=7 two cycles later; ack one cycle -> wr=0 next cycle.
REQ-034 List[1] invalid: slot 1 pulse -> wr stays 0; ov_slot_index wraps 1->0.
REQ-035 slot_cycles=2, ack withheld 5 cycles: overrun pulse on each skipped slot; addr stable throughout.
REQ-036 Ack held 2 cycles (double ack): exactly one request consumed, no spurious state change.
REQ-037 slot_num changed 8->3 while index=5: next pulse -> index=0.
REQ-038 Reset during ISSUE_S: wr=0 immediately; list reads invalid after release.
